cmd_assembler: RTL and testbench
================================

CMD_ASSEMBLER -- requirements
Module: cmd_assembler

Interface
REQ-001 Parameter ADDRW, default 24: address width in bits; SHALL be a multiple of 8; ABYTES = ADDRW/8.
REQ-002 Parameter OPCODEW, default 2: opcode width in bits; SHALL be at most 8.
REQ-003 Parameter TIMEOUT, default 255: maximum idle cycles allowed mid-frame before the frame is dropped.
REQ-004 Single clock; reset is synchronous and active-low; ports as follows:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset.
- byte_valid  in  1  inbound command byte present.
- byte_data  in  8  inbound command byte.
- byte_ready  out  1  block accepts byte_data this cycle.
- ready_in_aes  in  1  downstream AES request queue can take an instruction.
- ready_in_sha  in  1  downstream SHA request queue can take an instruction.
- valid_out  out  1  assembled instruction presented.
- opcode  out  OPCODEW  assembled opcode.
- key_addr  out  ADDRW  assembled key address.
- text_addr  out  ADDRW  assembled text address.
- dest_addr  out  ADDRW  assembled destination address.
- err  out  1  one-cycle pulse on a rejected header or a timed-out frame.

Function
REQ-005 A byte is accepted on a rising edge only when byte_valid and byte_ready are both 1.
REQ-006 State machine states: IDLE, KEY, TEXT, DEST, HOLD.
REQ-007 byte_ready SHALL be 1 in IDLE, KEY, TEXT and DEST; it SHALL be 0 in HOLD and whenever rst_n is 0.
REQ-008 IDLE, header byte accepted:
- byte_data[7:OPCODEW] == 0: opcode <= byte_data[OPCODEW-1:0]; next state is KEY if opcode[0] == 0 (AES), else TEXT (SHA).
- byte_data[7:OPCODEW] != 0: byte dropped, err = 1 for the next cycle, state remains IDLE.
REQ-009 KEY, TEXT and DEST each accept exactly ABYTES bytes, MSB first: field <= {field[ADDRW-9:0], byte_data}.
- A byte-index counter (0..ABYTES-1) is cleared on every state change.
- The last byte of KEY moves to TEXT, the last of TEXT moves to DEST, and the last of DEST moves to HOLD.
REQ-010 On entry to TEXT from IDLE (SHA frames), key_addr SHALL be cleared to 0.
REQ-011 valid_out SHALL be 1 exactly while in HOLD, i.e. starting the cycle after the last DEST byte is accepted.
- opcode, key_addr, text_addr and dest_addr SHALL be stable while valid_out = 1.
REQ-012 HOLD exit: the selected ready is ready_in_sha if opcode[0] == 1, else ready_in_aes.
- On an edge where valid_out = 1 and the selected ready = 1, the instruction transfers and the state goes to IDLE.
- The non-selected ready SHALL be ignored.
REQ-013 Timeout counter, in KEY, TEXT and DEST only:
- Cleared on every accepted byte and on every state entry; increments on each cycle with no accepted byte.
- On reaching TIMEOUT, the frame is dropped, state goes to IDLE, and err = 1 for one cycle.
- Counter width SHALL be clog2(TIMEOUT+1) and SHALL never wrap.
REQ-014 HOLD has no timeout; it waits indefinitely for the selected ready.
REQ-015 Field registers SHALL hold their last values after a transfer or drop; valid_out alone qualifies them.

Reset
REQ-016 When rst_n = 0 at a rising edge, reset SHALL take effect regardless of state, including mid-frame and HOLD:
- state = IDLE; all counters = 0; valid_out = 0; err = 0; opcode = 0; key_addr = 0; text_addr = 0; dest_addr = 0.
- Any partial frame is discarded.

Verification
REQ-017 AES frame 0x00,01 02 03,04 05 06,07 08 09 with ready_in_aes = 1 -> valid_out high one cycle after byte 10; opcode = 0, key_addr = 0x010203, text_addr = 0x040506, dest_addr = 0x070809; back in IDLE next cycle.
REQ-018 SHA frame 0x01,AA BB CC,11 22 33 with ready_in_sha = 0 for 5 cycles and ready_in_aes = 1 -> valid_out stays high for 6 cycles, outputs stable, key_addr = 0, byte_ready = 0 throughout HOLD.
REQ-019 Header 0x84 -> err pulses for 1 cycle, no state change; a following valid frame assembles correctly.
REQ-020 TIMEOUT = 4 and a frame stalls after 2 TEXT bytes -> err pulses at stall cycle 4, state returns to IDLE; the next header byte is treated as a header.
REQ-021 rst_n = 0 for one cycle in DEST, or while in HOLD -> next cycle valid_out = 0, all outputs = 0, byte_ready = 1.
REQ-022 Back-to-back frames with byte_valid held high and ready always 1 -> exactly one idle-byte gap (the HOLD cycle) between frames and no byte lost.

Source files
------------

// File: rtl/cmd_assembler.sv
// Command assembler: turns a byte stream (header + address bytes) into one wide
// instruction and holds it until the AES or SHA request queue takes it.
module cmd_assembler #(
  parameter int ADDRW   = 24,
  parameter int OPCODEW = 2,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  input  logic               ready_in_aes,
  input  logic               ready_in_sha,
  output logic               valid_out,
  output logic [OPCODEW-1:0] opcode,
  output logic [ADDRW-1:0]   key_addr,
  output logic [ADDRW-1:0]   text_addr,
  output logic [ADDRW-1:0]   dest_addr,
  output logic               err
);

  localparam int ABYTES = ADDRW / 8;
  localparam int BCW    = (ABYTES > 1) ? $clog2(ABYTES) : 1;
  localparam int TCW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {IDLE, KEY, TEXT, DEST, HOLD} state_t;

  state_t         state, state_next;
  logic [BCW-1:0] bcnt, bcnt_next;
  logic [TCW-1:0] tcnt, tcnt_next;
  logic           err_next;
  logic           accept;
  logic           hdr_bad;
  logic           last_byte;
  logic           sel_ready;
  logic           stall_hit;

  assign byte_ready = rst_n && (state != HOLD);
  assign accept     = byte_valid && byte_ready;
  assign valid_out  = (state == HOLD);

  // Any set bit above the opcode field makes the header illegal; the shift form
  // stays valid even when the opcode fills the whole byte.
  assign hdr_bad    = |(byte_data >> OPCODEW);
  assign last_byte  = (bcnt == BCW'(ABYTES - 1));
  assign sel_ready  = opcode[0] ? ready_in_sha : ready_in_aes;
  assign stall_hit  = (tcnt == TCW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      bcnt  <= '0;
      tcnt  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      bcnt  <= bcnt_next;
      tcnt  <= tcnt_next;
      err   <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    bcnt_next  = bcnt;
    tcnt_next  = tcnt;
    err_next   = 1'b0;
    unique case (state)
      IDLE: begin
        bcnt_next = '0;
        tcnt_next = '0;
        if (accept) begin
          if (hdr_bad) begin
            err_next = 1'b1;
          end else if (byte_data[0]) begin
            state_next = TEXT;
          end else begin
            state_next = KEY;
          end
        end
      end
      KEY, TEXT, DEST: begin
        if (accept) begin
          tcnt_next = '0;
          if (last_byte) begin
            bcnt_next = '0;
            if (state == KEY) begin
              state_next = TEXT;
            end else if (state == TEXT) begin
              state_next = DEST;
            end else begin
              state_next = HOLD;
            end
          end else begin
            bcnt_next = bcnt + 1'b1;
          end
        end else if (stall_hit) begin
          // The idle count reaches TIMEOUT on this edge: abandon the frame.
          state_next = IDLE;
          bcnt_next  = '0;
          tcnt_next  = '0;
          err_next   = 1'b1;
        end else begin
          tcnt_next = tcnt + 1'b1;
        end
      end
      HOLD: begin
        bcnt_next = '0;
        tcnt_next = '0;
        if (sel_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        bcnt_next  = '0;
        tcnt_next  = '0;
      end
    endcase
  end

  // Field registers keep their contents after a transfer or drop; only
  // valid_out says whether they mean anything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opcode    <= '0;
      key_addr  <= '0;
      text_addr <= '0;
      dest_addr <= '0;
    end else if (accept) begin
      unique case (state)
        IDLE: begin
          if (!hdr_bad) begin
            opcode <= byte_data[OPCODEW-1:0];
            if (byte_data[0]) begin
              key_addr <= '0;
            end
          end
        end
        KEY:     key_addr  <= ADDRW'({key_addr, byte_data});
        TEXT:    text_addr <= ADDRW'({text_addr, byte_data});
        DEST:    dest_addr <= ADDRW'({dest_addr, byte_data});
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_assembler.sv
// Directed bench for cmd_assembler (ADDRW=24, OPCODEW=2, TIMEOUT=4) with
// hand-computed expectations for each frame scenario.
module tb_cmd_assembler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        ready_in_aes;
  logic        ready_in_sha;
  logic        valid_out;
  logic [1:0]  opcode;
  logic [23:0] key_addr;
  logic [23:0] text_addr;
  logic [23:0] dest_addr;
  logic        err;

  int errors = 0;
  int checks = 0;

  cmd_assembler #(.ADDRW(24), .OPCODEW(2), .TIMEOUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .ready_in_aes (ready_in_aes),
    .ready_in_sha (ready_in_sha),
    .valid_out    (valid_out),
    .opcode       (opcode),
    .key_addr     (key_addr),
    .text_addr    (text_addr),
    .dest_addr    (dest_addr),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d);
    byte_valid = v;
    byte_data  = d;
    @(posedge clk);
    #1;
  endtask

  // Header, key bytes (AES only), text bytes, dest bytes, MSB first.
  task automatic sendFrame(input logic [7:0] hdr, input logic [23:0] k,
                           input logic [23:0] t, input logic [23:0] d);
    applyStimulus(1'b1, hdr);
    if (!hdr[0]) begin
      for (int i = 2; i >= 0; i--) applyStimulus(1'b1, k[i*8 +: 8]);
    end
    for (int i = 2; i >= 0; i--) applyStimulus(1'b1, t[i*8 +: 8]);
    for (int i = 2; i >= 0; i--) applyStimulus(1'b1, d[i*8 +: 8]);
    byte_valid = 1'b0;
  endtask

  task automatic checkFields(input string tag, input logic [1:0] op,
                             input logic [23:0] k, input logic [23:0] t,
                             input logic [23:0] d);
    checkOutput({tag, ".opcode"}, 64'(opcode), 64'(op));
    checkOutput({tag, ".key"}, 64'(key_addr), 64'(k));
    checkOutput({tag, ".text"}, 64'(text_addr), 64'(t));
    checkOutput({tag, ".dest"}, 64'(dest_addr), 64'(d));
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, ".valid"}, 64'(valid_out), 64'd0);
    checkOutput({tag, ".err"}, 64'(err), 64'd0);
    checkOutput({tag, ".ready"}, 64'(byte_ready), 64'd1);
    checkFields(tag, 2'd0, 24'h0, 24'h0, 24'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0]  stream [17];
    logic [1:0]  cap_op [2];
    logic [23:0] cap_key [2];
    logic [23:0] cap_text [2];
    logic [23:0] cap_dest [2];
    int idx, gaps, nvalid;
    logic rdy;

    rst_n = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    ready_in_aes = 1'b0; ready_in_sha = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checkOutput("rst.ready_low", 64'(byte_ready), 64'd0);
    checkOutput("rst.valid", 64'(valid_out), 64'd0);
    rst_n = 1'b1;
    #1;
    checkCleared("rst");

    // AES frame, downstream ready
    ready_in_aes = 1'b1;
    sendFrame(8'h00, 24'h010203, 24'h040506, 24'h070809);
    checkOutput("aes.valid", 64'(valid_out), 64'd1);
    checkOutput("aes.ready_hold", 64'(byte_ready), 64'd0);
    checkFields("aes", 2'd0, 24'h010203, 24'h040506, 24'h070809);
    applyStimulus(1'b0, 8'h00);
    checkOutput("aes.done", 64'(valid_out), 64'd0);
    checkOutput("aes.ready_idle", 64'(byte_ready), 64'd1);

    // SHA frame held for five cycles; the AES ready must be ignored
    ready_in_sha = 1'b0;
    sendFrame(8'h01, 24'h0, 24'hAABBCC, 24'h112233);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) ready_in_sha = 1'b1;
      checkOutput($sformatf("sha.valid%0d", i), 64'(valid_out), 64'd1);
      checkOutput($sformatf("sha.ready%0d", i), 64'(byte_ready), 64'd0);
      checkFields($sformatf("sha%0d", i), 2'd1, 24'h0, 24'hAABBCC, 24'h112233);
      applyStimulus(1'b0, 8'h00);
    end
    checkOutput("sha.done", 64'(valid_out), 64'd0);

    // Illegal header then a good frame
    applyStimulus(1'b1, 8'h84);
    byte_valid = 1'b0;
    checkOutput("bad.err", 64'(err), 64'd1);
    checkOutput("bad.valid", 64'(valid_out), 64'd0);
    checkOutput("bad.opcode", 64'(opcode), 64'd1);
    applyStimulus(1'b0, 8'h00);
    checkOutput("bad.err_clear", 64'(err), 64'd0);
    sendFrame(8'h02, 24'h0A0B0C, 24'h1A1B1C, 24'h2A2B2C);
    checkOutput("bad.next_valid", 64'(valid_out), 64'd1);
    checkFields("bad.next", 2'd2, 24'h0A0B0C, 24'h1A1B1C, 24'h2A2B2C);
    applyStimulus(1'b0, 8'h00);

    // Stall after two TEXT bytes of a SHA frame
    applyStimulus(1'b1, 8'h01);
    applyStimulus(1'b1, 8'h55);
    applyStimulus(1'b1, 8'h66);
    byte_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, 8'h00);
      checkOutput($sformatf("tmo.err_stall%0d", i), 64'(err), 64'd0);
    end
    applyStimulus(1'b0, 8'h00);
    checkOutput("tmo.err", 64'(err), 64'd1);
    checkOutput("tmo.text_kept", 64'(text_addr), 64'h1C5566);
    checkOutput("tmo.key_cleared", 64'(key_addr), 64'h0);
    applyStimulus(1'b0, 8'h00);
    checkOutput("tmo.err_clear", 64'(err), 64'd0);
    sendFrame(8'h00, 24'hC1C2C3, 24'hD1D2D3, 24'hE1E2E3);
    checkOutput("tmo.next_valid", 64'(valid_out), 64'd1);
    checkFields("tmo.next", 2'd0, 24'hC1C2C3, 24'hD1D2D3, 24'hE1E2E3);
    applyStimulus(1'b0, 8'h00);

    // Reset in DEST
    applyStimulus(1'b1, 8'h02);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'h30 + 8'(i));
    byte_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("rdest.ready_low", 64'(byte_ready), 64'd0);
    applyStimulus(1'b0, 8'h00);
    rst_n = 1'b1;
    #1;
    checkCleared("rdest");

    // Reset in HOLD
    ready_in_sha = 1'b0;
    sendFrame(8'h03, 24'h0, 24'h777777, 24'h888888);
    checkOutput("rhold.valid", 64'(valid_out), 64'd1);
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00);
    rst_n = 1'b1;
    #1;
    checkCleared("rhold");

    // Back-to-back frames, byte_valid held high
    ready_in_aes = 1'b1; ready_in_sha = 1'b1;
    stream = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'h30, 8'h31,
               8'h32, 8'h01, 8'h40, 8'h41, 8'h42, 8'h50, 8'h51, 8'h52};
    idx = 0; gaps = 0; nvalid = 0;
    for (int cyc = 0; cyc < 40 && nvalid < 2; cyc++) begin
      byte_valid = (idx < 17);
      byte_data  = (idx < 17) ? stream[idx] : 8'h00;
      #1;
      rdy = byte_ready;
      if (valid_out) begin
        cap_op[nvalid] = opcode; cap_key[nvalid] = key_addr;
        cap_text[nvalid] = text_addr; cap_dest[nvalid] = dest_addr;
        nvalid++;
      end
      if (byte_valid && !rdy) gaps++;
      @(posedge clk);
      #1;
      if (byte_valid && rdy) idx++;
    end
    byte_valid = 1'b0;
    checkOutput("b2b.bytes", 64'(idx), 64'd17);
    checkOutput("b2b.frames", 64'(nvalid), 64'd2);
    checkOutput("b2b.gaps", 64'(gaps), 64'd1);
    checkOutput("b2b.a_op", 64'(cap_op[0]), 64'd0);
    checkOutput("b2b.a_key", 64'(cap_key[0]), 64'h101112);
    checkOutput("b2b.a_text", 64'(cap_text[0]), 64'h202122);
    checkOutput("b2b.a_dest", 64'(cap_dest[0]), 64'h303132);
    checkOutput("b2b.b_op", 64'(cap_op[1]), 64'd1);
    checkOutput("b2b.b_key", 64'(cap_key[1]), 64'h0);
    checkOutput("b2b.b_text", 64'(cap_text[1]), 64'h404142);
    checkOutput("b2b.b_dest", 64'(cap_dest[1]), 64'h505152);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
